// File: rtl/traffic_seq.sv
// Editable traffic-light phase sequencer stepping a table of phases on a 1 s tick.
// Define TRAFFIC_SEQ_ALLRED_EN to insert a one-second all-red clearance before each advance.
module traffic_seq #(
  parameter int unsigned               NUM_LIGHTS  = 10,
  parameter int unsigned               MAX_PHASES  = 16,
  parameter int unsigned               DUR_W       = 6,
  parameter int unsigned               DEF_DUR     = 5,
  parameter logic [NUM_LIGHTS-1:0]     ALLRED_MASK = '1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            tick_sec_i,
  input  logic                            tick_blink_i,
  input  logic                            stop_i,
  input  logic                            next_i,
  input  logic                            plus_i,
  input  logic                            minus_i,
  input  logic                            ins_i,
  input  logic                            del_i,
  input  logic                            wr_en_i,
  input  logic [2*NUM_LIGHTS-1:0]         wr_mode_i,
  input  logic                            wr_flag_i,
  output logic [NUM_LIGHTS-1:0]           lights_o,
  output logic                            ped_on_o,
  output logic [$clog2(MAX_PHASES)-1:0]   phase_o,
  output logic [DUR_W-1:0]                remaining_o,
  output logic [DUR_W-1:0]                duration_o,
  output logic [$clog2(MAX_PHASES):0]     num_phases_o
);

  localparam int unsigned PW = $clog2(MAX_PHASES);
  localparam int unsigned NW = PW + 1;
  localparam int unsigned MW = 2 * NUM_LIGHTS;
  localparam logic [NW-1:0]    MaxNum = NW'(MAX_PHASES);
  localparam logic [DUR_W-1:0] DurMax = '1;
  localparam logic [DUR_W-1:0] DefDur = DUR_W'(DEF_DUR);

`ifdef TRAFFIC_SEQ_ALLRED_EN
  localparam bit AllRedEn = 1'b1;
`else
  localparam bit AllRedEn = 1'b0;
`endif

  logic [DUR_W-1:0]      dur_q  [MAX_PHASES];
  logic [DUR_W-1:0]      dur_d  [MAX_PHASES];
  logic [MW-1:0]         mode_q [MAX_PHASES];
  logic [MW-1:0]         mode_d [MAX_PHASES];
  logic [MAX_PHASES-1:0] flag_q, flag_d;
  logic [PW-1:0]         phase_q, phase_d, nxt;
  logic [NW-1:0]         num_q, num_d;
  logic [DUR_W-1:0]      rem_q, rem_d, dur_dec;
  logic                  blink_q, blink_d;
  logic                  clr_q, clr_d;
  logic [NUM_LIGHTS-1:0] lights_q, lights_d;
  logic                  ped_q, ped_d;
  logic                  last, tbl_op, expire;

  always_comb begin
    dur_d   = dur_q;
    mode_d  = mode_q;
    flag_d  = flag_q;
    phase_d = phase_q;
    num_d   = num_q;
    rem_d   = rem_q;
    clr_d   = clr_q;
    blink_d = blink_q ^ tick_blink_i;
    last    = ({1'b0, phase_q} == (num_q - NW'(1)));
    nxt     = last ? '0 : phase_q + PW'(1);
    tbl_op  = ins_i | del_i;
    expire  = tick_sec_i & ~stop_i & (rem_q == DUR_W'(1));
    dur_dec = (dur_q[phase_q] > DUR_W'(1)) ? dur_q[phase_q] - DUR_W'(1) : dur_q[phase_q];

    if (tbl_op) begin
      // Insert/delete cancel any clearance and act on the phase still on display.
      if (clr_q) begin
        clr_d = 1'b0;
        rem_d = dur_q[phase_q];
      end
      if (del_i) begin
        if (num_q != NW'(1)) begin
          for (int i = 0; i < MAX_PHASES - 1; i++) begin
            if (i >= int'(phase_q)) begin
              dur_d[i]  = dur_q[i+1];
              mode_d[i] = mode_q[i+1];
              flag_d[i] = flag_q[i+1];
            end
          end
          num_d   = num_q - NW'(1);
          phase_d = last ? '0 : phase_q;
          rem_d   = last ? dur_q[0] : dur_q[phase_q + PW'(1)];
        end
      end else if (num_q != MaxNum) begin
        for (int i = 1; i < MAX_PHASES; i++) begin
          if (i > int'(phase_q)) begin
            dur_d[i]  = dur_q[i-1];
            mode_d[i] = mode_q[i-1];
            flag_d[i] = flag_q[i-1];
          end
        end
        dur_d[phase_q]  = DefDur;
        mode_d[phase_q] = '0;
        flag_d[phase_q] = 1'b0;
        num_d           = num_q + NW'(1);
        rem_d           = DefDur;
      end
    end else begin
      if (clr_q) begin
        if (tick_sec_i | next_i) begin
          phase_d = nxt;
          rem_d   = dur_q[nxt];
          clr_d   = 1'b0;
        end
      end else if (expire | next_i) begin
        if (AllRedEn) begin
          clr_d = 1'b1;
          rem_d = '0;
        end else begin
          phase_d = nxt;
          rem_d   = dur_q[nxt];
        end
      end else if (tick_sec_i & ~stop_i & (rem_q > DUR_W'(1))) begin
        rem_d = rem_q - DUR_W'(1);
      end

      if (wr_en_i) begin
        mode_d[phase_q] = wr_mode_i;
        flag_d[phase_q] = wr_flag_i;
      end else if (plus_i) begin
        if (dur_q[phase_q] != DurMax) dur_d[phase_q] = dur_q[phase_q] + DUR_W'(1);
      end else if (minus_i) begin
        dur_d[phase_q] = dur_dec;
        if ((phase_d == phase_q) && (rem_d > dur_dec)) rem_d = dur_dec;
      end
    end
  end

  // Lamp drive reflects the state registered on the previous edge.
  always_comb begin
    lights_d = '0;
    for (int i = 0; i < NUM_LIGHTS; i++) begin
      case (mode_q[phase_q][2*i +: 2])
        2'b01:   lights_d[i] = 1'b1;
        2'b10:   lights_d[i] = blink_q;
        default: lights_d[i] = 1'b0;
      endcase
    end
    if (clr_q) lights_d = ALLRED_MASK;
    ped_d = flag_q[phase_q] & ~clr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_PHASES; i++) begin
        dur_q[i]  <= DefDur;
        mode_q[i] <= '0;
      end
      flag_q   <= '0;
      phase_q  <= '0;
      num_q    <= NW'(1);
      rem_q    <= DefDur;
      blink_q  <= 1'b1;
      clr_q    <= 1'b0;
      lights_q <= '0;
      ped_q    <= 1'b0;
    end else begin
      dur_q    <= dur_d;
      mode_q   <= mode_d;
      flag_q   <= flag_d;
      phase_q  <= phase_d;
      num_q    <= num_d;
      rem_q    <= rem_d;
      blink_q  <= blink_d;
      clr_q    <= clr_d;
      lights_q <= lights_d;
      ped_q    <= ped_d;
    end
  end

  assign lights_o     = lights_q;
  assign ped_on_o     = ped_q;
  assign phase_o      = phase_q;
  assign remaining_o  = rem_q;
  assign duration_o   = dur_q[phase_q];
  assign num_phases_o = num_q;

endmodule

// File: tb/tb_traffic_seq.sv
// Randomised bench for traffic_seq against a queue-based phase-table model.
module tb_traffic_seq;
  localparam int NL  = 10;
  localparam int NL2 = 2 * NL;
  localparam int MP  = 16;
  localparam int DW  = 6;
  localparam int DD  = 5;
  localparam int DMAX = (1 << DW) - 1;
`ifdef TRAFFIC_SEQ_ALLRED_EN
  localparam bit AllRed = 1'b1;
`else
  localparam bit AllRed = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic tick_sec, tick_blink, stop, next, plus, minus, ins, del, wr_en, wr_flag;
  logic [NL2-1:0] wr_mode;
  logic [NL-1:0]  lights;
  logic           ped_on;
  logic [3:0]     phase;
  logic [DW-1:0]  remaining, duration;
  logic [4:0]     num_phases;

  always #5 clk = ~clk;

  traffic_seq #(.NUM_LIGHTS(NL), .MAX_PHASES(MP), .DUR_W(DW), .DEF_DUR(DD)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick_sec_i   (tick_sec),
    .tick_blink_i (tick_blink),
    .stop_i       (stop),
    .next_i       (next),
    .plus_i       (plus),
    .minus_i      (minus),
    .ins_i        (ins),
    .del_i        (del),
    .wr_en_i      (wr_en),
    .wr_mode_i    (wr_mode),
    .wr_flag_i    (wr_flag),
    .lights_o     (lights),
    .ped_on_o     (ped_on),
    .phase_o      (phase),
    .remaining_o  (remaining),
    .duration_o   (duration),
    .num_phases_o (num_phases)
  );

  typedef struct packed {
    logic [DW-1:0]  dur;
    logic [NL2-1:0] mode;
    logic           flag;
  } entry_t;

  entry_t         tbl[$];
  int             m_ph, m_rem;
  bit             m_blink, m_clr;
  logic [NL-1:0]  exp_lights;
  logic           exp_ped;
  int             n_checks = 0;
  int             n_fails  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [NL-1:0] model_lights();
    logic [NL-1:0] l;
    logic [NL2-1:0] md;
    md = tbl[m_ph].mode;
    for (int i = 0; i < NL; i++) begin
      l[i] = (md[2*i +: 2] == 2'b01) || ((md[2*i +: 2] == 2'b10) && m_blink);
    end
    return m_clr ? {NL{1'b1}} : l;
  endfunction

  function automatic int next_idx();
    return (m_ph == tbl.size() - 1) ? 0 : m_ph + 1;
  endfunction

  task automatic model_update();
    entry_t e;
    if (ins || del) begin
      if (m_clr) begin
        m_clr = 1'b0;
        m_rem = tbl[m_ph].dur;
      end
      if (del) begin
        if (tbl.size() > 1) begin
          bit wrap;
          wrap = (m_ph == tbl.size() - 1);
          tbl.delete(m_ph);
          if (wrap) m_ph = 0;
          m_rem = tbl[m_ph].dur;
        end
      end else if (tbl.size() < MP) begin
        e.dur = DW'(DD); e.mode = '0; e.flag = 1'b0;
        tbl.insert(m_ph, e);
        m_rem = DD;
      end
    end else begin
      if (m_clr) begin
        if (tick_sec || next) begin
          m_ph = next_idx(); m_rem = tbl[m_ph].dur; m_clr = 1'b0;
        end
      end else if ((tick_sec && !stop && m_rem == 1) || next) begin
        if (AllRed) begin
          m_clr = 1'b1; m_rem = 0;
        end else begin
          m_ph = next_idx(); m_rem = tbl[m_ph].dur;
        end
      end else if (tick_sec && !stop && m_rem > 1) begin
        m_rem--;
      end
      e = tbl[m_ph];
      if (wr_en) begin
        e.mode = wr_mode; e.flag = wr_flag;
      end else if (plus) begin
        if (e.dur < DMAX) e.dur = e.dur + 1'b1;
      end else if (minus) begin
        if (e.dur > 1) e.dur = e.dur - 1'b1;
        if (m_rem > int'(e.dur)) m_rem = e.dur;
      end
      tbl[m_ph] = e;
    end
    if (tick_blink) m_blink = ~m_blink;
  endtask

  task automatic check_all();
    check_eq("phase", phase, m_ph);
    check_eq("remaining", remaining, m_rem);
    check_eq("duration", duration, tbl[m_ph].dur);
    check_eq("num_phases", num_phases, tbl.size());
    check_eq("lights", lights, exp_lights);
    check_eq("ped_on", ped_on, exp_ped);
  endtask

  task automatic clear_pulses();
    tick_sec = 0; tick_blink = 0; next = 0; plus = 0; minus = 0;
    ins = 0; del = 0; wr_en = 0;
  endtask

  // Applies the currently driven inputs for one clock, then checks against the model.
  task automatic step();
    exp_lights = model_lights();
    exp_ped    = m_clr ? 1'b0 : tbl[m_ph].flag;
    @(posedge clk);
    #1;
    model_update();
    clear_pulses();
    check_all();
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick_sec = 1; step();
      step();
    end
  endtask

  initial begin
    entry_t e0;
    int guard;
    rst_n = 0; stop = 0; wr_mode = '0; wr_flag = 0;
    clear_pulses();
    e0.dur = DW'(DD); e0.mode = '0; e0.flag = 1'b0;
    tbl = {};
    tbl.push_back(e0);
    m_ph = 0; m_rem = DD; m_blink = 1'b1; m_clr = 1'b0;
    exp_lights = '0; exp_ped = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all();
    rst_n = 1;

    // Countdown and wrap on a single-phase table.
    do_ticks(6);
    // Two inserts, then light0 on, light1 flashing.
    ins = 1; step();
    ins = 1; step();
    check_eq("num_after_ins", num_phases, 3);
    wr_en = 1; wr_mode = NL2'(4'b1001); wr_flag = 1; step();
    step();
    check_eq("light0_on", lights[0], 1);
    for (int i = 0; i < 6; i++) begin
      tick_blink = 1; step();
      step();
    end
    // Stop freezes countdown; next still advances; next+tick is one advance.
    stop = 1; do_ticks(10);
    next = 1; step();
    next = 1; tick_sec = 1; step();
    stop = 0;
    // Duration saturation both ways and remaining clamp.
    for (int i = 0; i < 7; i++) begin minus = 1; step(); end
    check_eq("dur_min", duration, 1);
    for (int i = 0; i < 70; i++) begin plus = 1; step(); end
    check_eq("dur_max", duration, DMAX);
    tick_sec = 1; step();
    for (int i = 0; i < 62; i++) begin minus = 1; step(); end
    // Fill the table, then overflow insert is ignored.
    guard = 0;
    while (tbl.size() < MP && guard < 40) begin ins = 1; step(); guard++; end
    ins = 1; step();
    check_eq("num_full", num_phases, MP);
    guard = 0;
    while (m_ph != tbl.size() - 1 && guard < 40) begin next = 1; step(); step(); guard++; end
    del = 1; step();
    check_eq("del_last_phase", phase, 0);
    check_eq("del_last_num", num_phases, MP - 1);
    for (int i = 0; i < 20; i++) begin del = 1; step(); end
    check_eq("num_min", num_phases, 1);

    // Randomised traffic.
    for (int c = 0; c < 4000; c++) begin
      tick_sec   = ($urandom_range(0, 3) == 0);
      next       = ($urandom_range(0, 15) == 0);
      tick_blink = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) stop = ~stop;
      if ($urandom_range(0, 3) == 0) begin
        del     = ($urandom_range(0, 5) == 0);
        ins     = ($urandom_range(0, 3) == 0);
        wr_en   = ($urandom_range(0, 2) == 0);
        plus    = ($urandom_range(0, 2) == 0);
        minus   = ($urandom_range(0, 2) == 0);
        wr_mode = NL2'($urandom);
        wr_flag = 1'($urandom);
        if (wr_en || plus || minus) begin
          tick_sec = 0; next = 0;
        end
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/traffic_seq.md
Name: traffic_seq

Overview:
Parametrised traffic-light phase sequencer, the successor to the fixed 10-phase controller. It holds an editable table of up to MAX_PHASES phases. Each phase has a duration, a per-light mode (off/on/flash) and a pedestrian flag. The block steps through the table on a 1 s tick and supports stop, manual next, duration trim, live phase edit, and phase insert/delete. It sits between the debounce/one-shot front end and the segment/greenman display blocks.

Parameters:
NUM_LIGHTS, 10, number of lamp outputs
MAX_PHASES, 16, table depth (power of 2, >=2)
DUR_W, 6, duration/countdown width in seconds
DEF_DUR, 5, duration loaded at reset and into inserted phases (1..2^DUR_W-1)
ALLRED_MASK, all-ones, lamps driven during clearance (optional feature only)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
tick_sec  in  1  one-cycle pulse, once per second
tick_blink  in  1  one-cycle pulse, toggles flash state
stop  in  1  level; 1 = freeze countdown
next  in  1  one-cycle pulse; advance phase now
plus  in  1  one-cycle pulse; current duration +1
minus  in  1  one-cycle pulse; current duration -1
ins  in  1  one-cycle pulse; insert blank phase at current index
del  in  1  one-cycle pulse; delete current phase
wr_en  in  1  one-cycle pulse; write wr_mode/wr_flag to current phase
wr_mode  in  2*NUM_LIGHTS  per-light mode, 00 off, 01 on, 10 flash, 11 = off
wr_flag  in  1  pedestrian flag for current phase
lights  out  NUM_LIGHTS  registered lamp drive
ped_on  out  1  registered pedestrian flag of current phase
phase  out  clog2(MAX_PHASES)  current phase index
remaining  out  DUR_W  seconds left in current phase (1..duration)
duration  out  DUR_W  duration of current phase
num_phases  out  clog2(MAX_PHASES)+1  active table length (1..MAX_PHASES)

Behaviour:
- Reset (async, rst_n=0): phase=0, num_phases=1, entry 0 duration=DEF_DUR with all modes off and flag 0, all other entries the same; remaining=DEF_DUR; blink state=1; lights=0; ped_on=0.
- Advance event = (tick_sec & !stop & remaining==1) | next.
  - On advance: phase = (phase==num_phases-1) ? 0 : phase+1; remaining = duration of new phase.
  - next and tick_sec in the same cycle produce one advance. next works while stop=1.
- tick_sec & !stop & remaining>1 & !next: remaining -= 1.
- Table-op priority per cycle: del > ins > wr_en > plus > minus. Only the highest-priority op executes; the rest are dropped.
  - Any ins/del suppresses advance and decrement in that cycle.
- plus: duration saturates at 2^DUR_W-1.
- minus: duration saturates at 1. If remaining > new duration, remaining is clamped to the new duration in the same cycle.
- ins:
  - Ignored when num_phases==MAX_PHASES.
  - Otherwise entries phase..num_phases-1 shift up by one; entry[phase] = {DEF_DUR, all off, flag 0}; num_phases += 1; phase unchanged; remaining = DEF_DUR.
- del:
  - Ignored when num_phases==1.
  - Otherwise entries phase+1..num_phases-1 shift down; num_phases -= 1.
  - If the deleted phase was the last one, phase wraps to 0.
  - remaining = duration of the new current entry.
- wr_en: overwrites modes and flag of the current entry. Duration and remaining are unchanged.
- Blink state toggles on each tick_blink.
- lights[i] (registered, 1-cycle latency after any state change): on → 1, flash → blink state, off/11 → 0.
- ped_on follows the current entry flag with the same latency.
- Entries at index >= num_phases hold stale data and are never displayed.
- All shifts complete in one cycle. There is no busy output.

Optional Feature:
TRAFFIC_SEQ_ALLRED_EN
- Defined: every timed or next-driven advance first enters a one-second clearance interval.
  - During clearance: lights=ALLRED_MASK, ped_on=0, remaining=0, phase still shows the old index.
  - The next tick_sec (ignoring stop) completes the move to the new phase.
  - A next pulse during clearance completes it immediately.
  - ins/del during clearance abort the clearance and act on the old phase.
- Undefined: advances take effect directly; remaining never reads 0.

Test Plan:
- Reset, then 4 tick_sec pulses → remaining 5,4,3,2 then 1; 5th tick → phase stays 0 (num_phases=1), remaining=5.
- ins ×2, then wr_en with mode light0=on, light1=flash → num_phases=3; lights[0]=1, lights[1] toggles on each tick_blink.
- stop=1, 10 tick_sec → remaining frozen; next pulse → phase+1, remaining=new duration; next+tick_sec in the same cycle → single advance.
- minus to duration=1 then minus again → stays 1; plus ×70 with DUR_W=6 → saturates at 63; minus with remaining=4 → remaining clamped to the new duration.
- Fill to MAX_PHASES, ins → ignored; on last phase, del → phase=0, num_phases=15; delete down to 1, del → ignored.
- ALLRED_EN build: phase expiry → lights=ALLRED_MASK, remaining=0 for one tick_sec, then the new phase; next during clearance → immediate entry.
